// File: rtl/axi4_thread_tracker.sv
// axi4_thread_tracker
// Per-master table of open AXI4 threads feeding the crossbar dependence
// checker. Each entry holds an ID, its target slave and an outstanding count.
// The lookup for the current request ID is combinational. Entries are
// allocated when an address is accepted and retired on final responses.
// Optional feature: define AXI4_THREAD_TRACKER_ERR_EN to build the sticky
// trackErr protocol-error flag. Without it, trackErr is tied low.

module axi4_thread_tracker #(
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_THREADS      = 2,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [MASTERID_WIDTH-1:0]   currTransID,
  input  logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
  input  logic                        openTransInc,
  input  logic                        openTransDec,
  input  logic [MASTERID_WIDTH-1:0]   decTransID,
  output logic                        threadAvail,
  output logic                        threadValid,
  output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
  output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
  output logic                        allIdle,
  output logic                        trackErr
);

  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_MAX = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_ONE = OPEN_TRANS_WIDTH'(1);

  typedef struct packed {
    logic                        valid;
    logic [MASTERID_WIDTH-1:0]   id;
    logic [NUM_SLAVES_WIDTH-1:0] slave;
    logic [OPEN_TRANS_WIDTH-1:0] cnt;
  } entryT;

  entryT entryQ [NUM_THREADS];
  entryT entryD [NUM_THREADS];

  logic [NUM_THREADS-1:0] curMatch;
  logic [NUM_THREADS-1:0] decMatch;
  logic [NUM_THREADS-1:0] incHitVec;
  logic [NUM_THREADS-1:0] decHitVec;
  logic [NUM_THREADS-1:0] allocSel;
  logic                   anyCurMatch;
  logic                   anyDecMatch;
  logic                   anyFree;
  logic                   allocInc;

  // Match both the request ID and the completing ID against valid entries.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      curMatch[i] = entryQ[i].valid && (entryQ[i].id == currTransID);
      decMatch[i] = entryQ[i].valid && (entryQ[i].id == decTransID);
    end
  end

  assign anyCurMatch = |curMatch;
  assign anyDecMatch = |decMatch;
  assign incHitVec   = openTransInc ? curMatch : '0;
  assign decHitVec   = openTransDec ? decMatch : '0;

  // Pick the lowest-index free entry, using free status before the edge so a
  // slot released by a same-cycle Dec is never handed to the Inc.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    allocSel = '0;
    anyFree  = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!entryQ[i].valid && !anyFree) begin
        allocSel[i] = 1'b1;
        anyFree     = 1'b1;
      end
    end
  end

  assign allocInc = openTransInc && !anyCurMatch && anyFree;

  // Compute the next table state from Inc, Dec and allocation.
  always_comb begin
    entryD = entryQ;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (incHitVec[i] && decHitVec[i]) begin
        // Same entry gains and loses one: count and valid unchanged.
        entryD[i] = entryQ[i];
      end else if (incHitVec[i]) begin
        if (entryQ[i].cnt != CNT_MAX) begin
          entryD[i].cnt = entryQ[i].cnt + CNT_ONE;
        end
      end else if (decHitVec[i]) begin
        entryD[i].cnt = entryQ[i].cnt - CNT_ONE;
        if (entryQ[i].cnt == CNT_ONE) begin
          entryD[i].valid = 1'b0;
        end
      end else if (allocInc && allocSel[i]) begin
        entryD[i].valid = 1'b1;
        entryD[i].id    = currTransID;
        entryD[i].slave = currTransSlaveID;
        entryD[i].cnt   = CNT_ONE;
      end
    end
  end

  // Table register; reset clears the whole table asynchronously.
  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      // NOTE: the table is small and flop-based, so every field is reset; id/slave are reset only to keep outputs deterministic.
      for (int i = 0; i < NUM_THREADS; i++) begin
        entryQ[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      for (int i = 0; i < NUM_THREADS; i++) begin
        entryQ[i] <= entryD[i];
      end
    end
  end

  // Combinational lookup results and occupancy flags.
  always_comb begin
    threadCount   = '0;
    threadSlaveID = '0;
    threadAvail   = 1'b0;
    allIdle       = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (curMatch[i]) begin
        threadCount   = threadCount | entryQ[i].cnt;
        threadSlaveID = threadSlaveID | entryQ[i].slave;
      end
      threadAvail = threadAvail | ~entryQ[i].valid;
      allIdle     = allIdle & ~entryQ[i].valid;
    end
  end

  assign threadValid = anyCurMatch;

`ifdef AXI4_THREAD_TRACKER_ERR_EN
  logic errEvent;
  logic trackErrQ;

  // Flag full-table allocation, increment past max, and unmatched decrement.
  always_comb begin
    errEvent = 1'b0;
    if (openTransInc && !anyCurMatch && !anyFree) begin
      errEvent = 1'b1;
    end
    if (openTransInc && anyCurMatch && (threadCount == CNT_MAX) &&
        !(|(incHitVec & decHitVec))) begin
      errEvent = 1'b1;
    end
    if (openTransDec && !anyDecMatch) begin
      errEvent = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      trackErrQ <= 1'b0;
    end else begin
      trackErrQ <= trackErrQ | errEvent;
    end
  end

  assign trackErr = trackErrQ;
`else
  assign trackErr = 1'b0;
`endif

endmodule

// File: doc/axi4_thread_tracker.md
Name: axi4_thread_tracker

Overview:
Per-master table of open AXI4 threads that sits directly upstream of the crossbar dependence checker in each master address path. It stores up to NUM_THREADS active IDs, each with its target slave and outstanding-transaction count. For the current request ID it returns the thread-match/avail/count/slave lookup. It allocates entries on address acceptance and retires them on final responses.

Parameters:
NUM_SLAVES_WIDTH, 2, bits encoding slave number (incl. derrSlave)
MASTERID_WIDTH, 4, bits in master ID
NUM_THREADS, 2, table entries (1..8)
OPEN_TRANS_MAX, 3, max outstanding transactions per thread
OPEN_TRANS_WIDTH, 2, count width; must hold OPEN_TRANS_MAX

Ports:
sysClk  in  1  clock
sysReset  in  1  asynchronous, active-low reset
currTransID  in  MASTERID_WIDTH  ID of request being qualified
currTransSlaveID  in  NUM_SLAVES_WIDTH  decoded target of current request
openTransInc  in  1  address handshake accepted for currTransID this cycle
openTransDec  in  1  final response (RLAST or B) completed this cycle
decTransID  in  MASTERID_WIDTH  ID of completing response
threadAvail  out  1  at least one free entry
threadValid  out  1  valid entry matches currTransID
threadCount  out  OPEN_TRANS_WIDTH  count of matched entry, else 0
threadSlaveID  out  NUM_SLAVES_WIDTH  slave of matched entry, else 0
allIdle  out  1  no valid entries
trackErr  out  1  protocol error indication (see Optional Feature)

Behaviour:
- Entry state: valid, id, slave, cnt. Reset clears all valid, cnt=0. Outputs after reset: threadAvail=1, threadValid=0, threadCount=0, threadSlaveID=0, allIdle=1, trackErr=0.
- Lookup is combinational: zero cycles from currTransID to threadValid/threadCount/threadSlaveID. At most one entry matches any ID by construction. Updates take effect on the next clock edge.
- Inc, matching entry exists: cnt+1 on that entry; slave field unchanged.
- Inc, no match: allocate the lowest-index free entry with id=currTransID, slave=currTransSlaveID, cnt=1.
- Inc, no match and table full: no update; error event.
- Inc on an entry with cnt==OPEN_TRANS_MAX: cnt saturates; error event.
- Dec: the entry matching decTransID decrements cnt. When cnt goes 1->0, valid clears in the same edge.
- Dec with no matching entry: no update; error event.
- Inc and Dec same cycle, same entry: cnt unchanged and entry stays valid, including when cnt==1.
- Inc and Dec same cycle, different entries: both apply independently. The entry freed by the Dec is not eligible for the same-cycle allocation; allocation uses free status before the edge.
- Inc allocation while Dec frees the last slot in the same cycle: the Inc counts as table full (error), because the checker must only assert Inc when threadAvail was 1.
- threadAvail = OR of ~valid. allIdle = AND of ~valid.
- Reset asserted mid-operation clears the table asynchronously. In-flight counts are lost; the system must reset all interconnect stages together.

Optional Feature:
Macro AXI4_THREAD_TRACKER_ERR_EN.
- Defined: each error event (full-table allocate, increment past max, unmatched decrement) sets a sticky trackErr register. It clears only on reset and is visible the cycle after the event.
- Undefined: no error logic is synthesised; trackErr is tied 0 and table behaviour is identical.

Test Plan:
- Reset, then currTransID=4'h5 -> threadAvail=1, threadValid=0, allIdle=1, trackErr=0.
- Inc ID 5 to slave 2, three times -> threadValid=1, threadSlaveID=2, threadCount=3. A fourth Inc leaves threadCount=3 and sets trackErr=1 with the macro (0 without).
- Inc ID 5, then Inc ID 9 (slave 1), with NUM_THREADS=2 -> threadAvail=0. An Inc on ID 3 leaves the table unchanged and sets trackErr.
- ID 5 at cnt=1: Inc and Dec of ID 5 in the same cycle -> entry stays valid, threadCount=1. A following lone Dec -> threadValid=0, threadAvail=1.
- Dec with decTransID=4'hA while unallocated -> no state change, trackErr=1 next cycle.
- Reset pulse while two entries are valid -> allIdle=1 and threadAvail=1 immediately, while reset is still low.
